// File: rtl/crc_serial_engine.sv
// -----------------------------------------------------------------------------
// crc_serial_engine
// Parametrised bit-serial MSB-first CRC generator with frame control. A start
// pulse seeds the register and opens a frame. Message bits are accepted under
// data_valid while in_ready is high. The bit flagged by data_last closes the
// message. The engine then serialises the (XOROUT-masked) CRC MSB first, and
// pulses done when the frame is complete.
//
// Optional feature (macro CRC_CHECK_EN): a frame opened with check_mode=1
// consumes CRC_W trailing bits instead of emitting them, compares them with
// the computed CRC and reports crc_ok / crc_err.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_l       in   asynchronous active-low reset
//   start         in   one-cycle pulse, seeds INIT and opens (or restarts) a frame
//   data_valid    in   data_in is valid this cycle
//   data_in       in   serial message bit, MSB first
//   data_last     in   marks the final message bit (qualified by data_valid)
//   in_ready      out  engine accepts data bits
//   crc_bit_out   out  serialised CRC bit
//   crc_bit_valid out  crc_bit_out is valid
//   crc_out       out  [CRC_W] final CRC, held until the next start
//   done          out  one-cycle frame-complete pulse
//   busy          out  frame in progress (RUN or APPEND)
//   check_mode    in   (CRC_CHECK_EN) sampled at start, selects check frame
//   crc_ok        out  (CRC_CHECK_EN) received CRC matched
//   crc_err       out  (CRC_CHECK_EN) received CRC mismatched
// -----------------------------------------------------------------------------
module crc_serial_engine #(
  parameter int unsigned      CRC_W  = 5,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(5'b00101),
  parameter logic [CRC_W-1:0] INIT   = {CRC_W{1'b1}},
  parameter logic [CRC_W-1:0] XOROUT = {CRC_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic             data_last,
  output logic             in_ready,
  output logic             crc_bit_out,
  output logic             crc_bit_valid,
  output logic [CRC_W-1:0] crc_out,
  output logic             done,
  output logic             busy
`ifdef CRC_CHECK_EN
  ,
  input  logic             check_mode,
  output logic             crc_ok,
  output logic             crc_err
`endif
);

  localparam int unsigned      CNT_W    = (CRC_W > 1) ? $clog2(CRC_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_APPEND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CRC_W-1:0] r_crc, w_crc_nxt;
  logic [CRC_W-1:0] r_shift, w_shift_nxt;
  logic [CRC_W-1:0] r_crc_out, w_crc_out_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_chk, w_chk_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_bit_out, w_bit_out_nxt;
  logic             r_bit_valid, w_bit_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             w_fb;
  logic [CRC_W-1:0] w_step;
`ifdef CRC_CHECK_EN
  logic             r_mis, w_mis_nxt;
  logic             r_ok, w_ok_nxt;
  logic             r_err, w_err_nxt;
  logic             w_bit_mis;
`endif

  // One LFSR step for the current data_in bit
  assign w_fb   = data_in ^ r_crc[CRC_W-1];
  assign w_step = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

`ifdef CRC_CHECK_EN
  // Received bit versus the expected CRC bit currently at the shifter MSB
  assign w_bit_mis = data_in ^ r_shift[CRC_W-1];
`endif

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath next values and registered-output next values
  always_comb begin
    w_state_nxt   = r_state;
    w_crc_nxt     = r_crc;
    w_shift_nxt   = r_shift;
    w_crc_out_nxt = r_crc_out;
    w_cnt_nxt     = r_cnt;
    w_chk_nxt     = r_chk;
`ifdef CRC_CHECK_EN
    w_mis_nxt     = r_mis;
    w_ok_nxt      = r_ok;
    w_err_nxt     = r_err;
`endif

    if (start) begin
      // start wins in every state: (re)open the frame, crc_out is left alone
      w_state_nxt = S_RUN;
      w_crc_nxt   = INIT;
      w_cnt_nxt   = '0;
`ifdef CRC_CHECK_EN
      w_chk_nxt   = check_mode;
      w_mis_nxt   = 1'b0;
      w_ok_nxt    = 1'b0;
      w_err_nxt   = 1'b0;
`else
      w_chk_nxt   = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end

        S_RUN: begin
          if (data_valid) begin
            w_crc_nxt = w_step;
            if (data_last) begin
              // Shifter holds the masked CRC so the first bit leaves next cycle
              w_state_nxt = S_APPEND;
              w_cnt_nxt   = '0;
              w_shift_nxt = w_step ^ XOROUT;
            end
          end
        end

        S_APPEND: begin
          // Register is frozen in APPEND, so repeated loads at cnt=0 are harmless
          if (r_cnt == '0) begin
            w_crc_out_nxt = r_crc ^ XOROUT;
          end
          if (r_chk) begin
`ifdef CRC_CHECK_EN
            if (data_valid) begin
              w_mis_nxt   = r_mis | w_bit_mis;
              w_shift_nxt = {r_shift[CRC_W-2:0], 1'b0};
              if (r_cnt == CNT_LAST) begin
                w_state_nxt = S_DONE;
                w_ok_nxt    = ~(r_mis | w_bit_mis);
                w_err_nxt   = r_mis | w_bit_mis;
              end else begin
                w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
              end
            end
`endif
          end else begin
            w_shift_nxt = {r_shift[CRC_W-2:0], 1'b0};
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
            end
          end
        end

        S_DONE: begin
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state so they align with it
    w_in_ready_nxt  = (w_state_nxt == S_RUN) ||
                      ((w_state_nxt == S_APPEND) && w_chk_nxt);
    w_busy_nxt      = (w_state_nxt == S_RUN) || (w_state_nxt == S_APPEND);
    w_bit_valid_nxt = (w_state_nxt == S_APPEND) && !w_chk_nxt;
    w_bit_out_nxt   = w_bit_valid_nxt & w_shift_nxt[CRC_W-1];
    w_done_nxt      = (w_state_nxt == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_crc       <= INIT;
      r_shift     <= '0;
      r_crc_out   <= '0;
      r_cnt       <= '0;
      r_chk       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
`ifdef CRC_CHECK_EN
      r_mis       <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_crc       <= w_crc_nxt;
      r_shift     <= w_shift_nxt;
      r_crc_out   <= w_crc_out_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chk       <= w_chk_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_bit_out   <= w_bit_out_nxt;
      r_bit_valid <= w_bit_valid_nxt;
      r_done      <= w_done_nxt;
`ifdef CRC_CHECK_EN
      r_mis       <= w_mis_nxt;
      r_ok        <= w_ok_nxt;
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign in_ready      = r_in_ready;
  assign busy          = r_busy;
  assign crc_bit_out   = r_bit_out;
  assign crc_bit_valid = r_bit_valid;
  assign crc_out       = r_crc_out;
  assign done          = r_done;
`ifdef CRC_CHECK_EN
  assign crc_ok        = r_ok;
  assign crc_err       = r_err;
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// -----------------------------------------------------------------------------
// tb_crc_serial_engine
// Two engines (INIT=0/XOROUT=0 and default parameters) share one randomized
// stimulus stream. Expected results come from a polynomial long-division model;
// a negedge monitor pops them from per-engine queues whenever done pulses.
// -----------------------------------------------------------------------------
module tb_crc_serial_engine;

  localparam int unsigned W       = 5;
  localparam logic [31:0] TB_POLY = 32'h05;
  localparam logic [31:0] ONES    = 32'h1F;

  typedef struct {
    logic [31:0] crc;
    int          done_cyc;
    bit          chk;
    bit          ok;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_l, start, data_valid, data_in, data_last;
`ifdef CRC_CHECK_EN
  logic check_mode;
  logic ok0, ok1, err0, err1;
`endif
  logic in_ready0, in_ready1, bit_out0, bit_out1, bit_valid0, bit_valid1;
  logic done0, done1, busy0, busy1;
  logic [W-1:0] crc_out0, crc_out1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  int          nb[2];
  logic [31:0] bits[2];

  always @(posedge clk) cyc <= cyc + 1;

  crc_serial_engine #(.CRC_W(W), .POLY(5'b00101), .INIT(5'b00000), .XOROUT(5'b00000)) u_dut0 (
    .clk(clk), .reset_l(reset_l), .start(start), .data_valid(data_valid),
    .data_in(data_in), .data_last(data_last), .in_ready(in_ready0),
    .crc_bit_out(bit_out0), .crc_bit_valid(bit_valid0), .crc_out(crc_out0),
    .done(done0), .busy(busy0)
`ifdef CRC_CHECK_EN
    , .check_mode(check_mode), .crc_ok(ok0), .crc_err(err0)
`endif
  );

  crc_serial_engine #(.CRC_W(W)) u_dut1 (
    .clk(clk), .reset_l(reset_l), .start(start), .data_valid(data_valid),
    .data_in(data_in), .data_last(data_last), .in_ready(in_ready1),
    .crc_bit_out(bit_out1), .crc_bit_valid(bit_valid1), .crc_out(crc_out1),
    .done(done1), .busy(busy1)
`ifdef CRC_CHECK_EN
    , .check_mode(check_mode), .crc_ok(ok1), .crc_err(err1)
`endif
  );

  task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  // CRC as remainder of (M(x)*x^W + INIT*x^len) mod (x^W + POLY), then XOROUT
  function automatic logic [31:0] ref_crc(input bit msg[$], input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xorout);
    bit a[$];
    logic [31:0] r;
    int n;
    n = msg.size();
    a = msg;
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = a[i] ^ init[w-1-i];
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ poly[w-j];
      end
    end
    r = '0;
    for (int j = 0; j < w; j++) r = {r[30:0], a[n+j]};
    return r ^ xorout;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Monitor: collect serial bits, check each completed frame on done
  always @(negedge clk) begin : mon
    exp_t e;
    logic bv, bo, dn;
    logic [31:0] co;
    for (int d = 0; d < 2; d++) begin
      bv = (d == 0) ? bit_valid0 : bit_valid1;
      bo = (d == 0) ? bit_out0   : bit_out1;
      dn = (d == 0) ? done0      : done1;
      co = (d == 0) ? 32'(crc_out0) : 32'(crc_out1);
      if (!reset_l) begin
        nb[d] = 0;
        bits[d] = '0;
      end else begin
        if (bv) begin
          bits[d] = {bits[d][30:0], bo};
          nb[d]++;
        end
        if (dn) begin
          if (qsize(d) == 0) begin
            cmp("unexpected_done", d, 32'(dn), 32'd0);
          end else begin
            e = qpop(d);
            cmp("crc_out", d, co, e.crc);
            if (!e.chk) begin
              cmp("serial_bit_count", d, 32'(nb[d]), 32'(W));
              cmp("serial_bits", d, bits[d], e.crc);
              cmp("done_latency", d, 32'(cyc), 32'(e.done_cyc));
            end else begin
              cmp("no_bits_in_check", d, 32'(nb[d]), 32'd0);
            end
`ifdef CRC_CHECK_EN
            cmp("crc_ok", d, 32'((d == 0) ? ok0 : ok1), 32'(e.ok));
            cmp("crc_err", d, 32'((d == 0) ? err0 : err1), 32'(e.err));
`endif
          end
          nb[d] = 0;
          bits[d] = '0;
        end
        if (start) begin
          nb[d] = 0;
          bits[d] = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    data_valid = 1'b0;
    data_in    = 1'($urandom);
    data_last  = 1'($urandom);
    step();
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      cmp({name, "_in_ready"},  d, 32'((d == 0) ? in_ready0  : in_ready1),  32'd0);
      cmp({name, "_busy"},      d, 32'((d == 0) ? busy0      : busy1),      32'd0);
      cmp({name, "_bit_valid"}, d, 32'((d == 0) ? bit_valid0 : bit_valid1), 32'd0);
      cmp({name, "_bit_out"},   d, 32'((d == 0) ? bit_out0   : bit_out1),   32'd0);
      cmp({name, "_done"},      d, 32'((d == 0) ? done0      : done1),      32'd0);
      cmp({name, "_crc_out"},   d, (d == 0) ? 32'(crc_out0) : 32'(crc_out1), 32'd0);
`ifdef CRC_CHECK_EN
      cmp({name, "_crc_ok"},    d, 32'((d == 0) ? ok0  : ok1),  32'd0);
      cmp({name, "_crc_err"},   d, 32'((d == 0) ? err0 : err1), 32'd0);
`endif
    end
  endtask

  // Drives one frame; gold >= 0 overrides the model with a fixed expectation
  task automatic run_frame(input bit msg[$], input int abort_after, input bit kill,
                           input int gap_at, input int gap_len, input bit rnd_stall,
                           input bit chk_mode, input bit trail[$],
                           input int gold0, input int gold1);
    exp_t e0, e1;
    logic [31:0] m0, m1, tv;
    int n;
    m0 = ref_crc(msg, W, TB_POLY, 32'd0, 32'd0);
    m1 = ref_crc(msg, W, TB_POLY, ONES, ONES);
    if (gold0 >= 0) m0 = 32'(gold0);
    if (gold1 >= 0) m1 = 32'(gold1);
    tv = '0;
    foreach (trail[k]) tv = {tv[30:0], trail[k]};

    // data alongside start is never taken
    start      = 1'b1;
`ifdef CRC_CHECK_EN
    check_mode = chk_mode;
`endif
    data_valid = 1'($urandom);
    data_in    = 1'($urandom);
    data_last  = 1'($urandom);
    step();
    start = 1'b0;

    for (int i = 0; i < msg.size(); i++) begin
      if (abort_after >= 0 && i == abort_after) begin
        data_valid = 1'b0;
        return;
      end
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          idle_cycle();
          cmp("in_ready_in_gap", 0, 32'(in_ready0), 32'd1);
          cmp("in_ready_in_gap", 1, 32'(in_ready1), 32'd1);
        end
      end
      if (rnd_stall && $urandom_range(0, 3) == 0) idle_cycle();
      cmp("in_ready_run", 0, 32'(in_ready0), 32'd1);
      data_valid = 1'b1;
      data_in    = msg[i];
      data_last  = (i == msg.size() - 1);
      if (data_last && !kill) begin
        e0.crc = m0; e0.chk = chk_mode; e0.done_cyc = cyc + 1 + int'(W);
        e1.crc = m1; e1.chk = chk_mode; e1.done_cyc = cyc + 1 + int'(W);
        e0.ok  = chk_mode && (trail.size() == W) && (tv == m0);
        e1.ok  = chk_mode && (trail.size() == W) && (tv == m1);
        e0.err = chk_mode && !e0.ok;
        e1.err = chk_mode && !e1.ok;
        q0.push_back(e0);
        q1.push_back(e1);
      end
      step();
    end

    if (kill) begin
      data_valid = 1'b0;
      step();
      cmp("in_append_before_reset", 0, 32'(bit_valid0), 32'd1);
      #2 reset_l = 1'b0;
      #1 check_all_zero("async_reset_mid_frame");
      repeat (2) step();
      reset_l = 1'b1;
      return;
    end

    if (chk_mode) begin
      foreach (trail[k]) begin
        if (rnd_stall && $urandom_range(0, 2) == 0) idle_cycle();
        cmp("in_ready_check", 0, 32'(in_ready0), 32'd1);
        data_valid = 1'b1;
        data_in    = trail[k];
        data_last  = 1'($urandom);
        step();
      end
    end

    data_valid = 1'b0;
    n = 0;
    while (busy0 && n < 4 * int'(W) + 10) begin
      step();
      n++;
    end
    cmp("frame_end_timeout", 0, 32'(busy0), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit msg[$];
    bit trail[$];
    bit none[$];
    int len;
    reset_l    = 1'b1;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = 1'b0;
    data_last  = 1'b0;
`ifdef CRC_CHECK_EN
    check_mode = 1'b0;
`endif
    #2 reset_l = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) step();
    reset_l = 1'b1;
    step();

    // 1,0,0,0 : INIT=0/XOROUT=0 engine gives 01101
    msg = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(msg, -1, 1'b0, -1, 0, 1'b0, 1'b0, none, 5'b01101, -1);

    // five zeros : default engine gives 10011
    msg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_frame(msg, -1, 1'b0, -1, 0, 1'b0, 1'b0, none, 0, 5'b10011);

    // same frame with a 3-cycle data_valid gap
    run_frame(msg, -1, 1'b0, 2, 3, 1'b0, 1'b0, none, 0, 5'b10011);

    // aborted after 2 bits, then a complete 1,0,0,0 frame
    msg = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(msg, 2, 1'b0, -1, 0, 1'b0, 1'b0, none, -1, -1);
    msg = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(msg, -1, 1'b0, -1, 0, 1'b0, 1'b0, none, 5'b01101, -1);

    // reset while serialising, then recover
    msg = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    run_frame(msg, -1, 1'b1, -1, 0, 1'b0, 1'b0, none, -1, -1);
    msg = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame(msg, -1, 1'b0, -1, 0, 1'b0, 1'b0, none, 5'b01101, -1);

    // randomized frames with stalls and occasional aborts
    for (int f = 0; f < 30; f++) begin
      msg.delete();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) msg.push_back(1'($urandom));
      if ($urandom_range(0, 5) == 0)
        run_frame(msg, $urandom_range(0, len - 1), 1'b0, -1, 0, 1'b1, 1'b0, none, -1, -1);
      else
        run_frame(msg, -1, 1'b0, -1, 0, 1'b1, 1'b0, none, -1, -1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) idle_cycle();
    end

`ifdef CRC_CHECK_EN
    msg   = '{1'b1, 1'b0, 1'b0, 1'b0};
    trail = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_frame(msg, -1, 1'b0, -1, 0, 1'b0, 1'b1, trail, 5'b01101, -1);
    trail = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    run_frame(msg, -1, 1'b0, -1, 0, 1'b1, 1'b1, trail, 5'b01101, -1);
    for (int f = 0; f < 10; f++) begin
      logic [31:0] good;
      msg.delete();
      trail.delete();
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) msg.push_back(1'($urandom));
      good = ref_crc(msg, W, TB_POLY, 32'd0, 32'd0);
      for (int k = 0; k < int'(W); k++)
        trail.push_back(($urandom_range(0, 1) == 0) ? good[W-1-k] : 1'($urandom));
      run_frame(msg, -1, 1'b0, -1, 0, 1'b1, 1'b1, trail, -1, -1);
    end
`else
    trail.delete();
`endif

    repeat (20) idle_cycle();
    cmp("pending_frames", 0, 32'(q0.size()), 32'd0);
    cmp("pending_frames", 1, 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
